// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback sequencer for the 32x32 RISC-V register file.
// Two producers (ALU, load unit) are arbitrated round-robin over valid/ready,
// queued in a DEPTH-entry FIFO and drained onto the register file write
// channel at one write per cycle. Writes to x0 are accepted and dropped.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   alu_valid/ready/addr/data   ALU write request
//   mem_valid/ready/addr/data   load unit write request
//   wr_ena/addr/data            register file write channel (registered)
//   pending                     per-register "write in flight" mask
//   count                       FIFO occupancy
//   busy                        count != 0 or wr_ena
// Optional (macro REGFILE_WB_FORWARD_EN):
//   fwd_addr0/1 -> fwd_hit0/1, fwd_data0/1   youngest in-flight value lookup
module regfile_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [4:0]                   alu_addr,
    input  logic [31:0]                  alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [4:0]                   mem_addr,
    input  logic [31:0]                  mem_data,
    output logic                         wr_ena,
    output logic [4:0]                   wr_addr,
    output logic [31:0]                  wr_data,
    output logic [31:0]                  pending,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
`ifdef REGFILE_WB_FORWARD_EN
    ,
    input  logic [4:0]                   fwd_addr0,
    input  logic [4:0]                   fwd_addr1,
    output logic                         fwd_hit0,
    output logic                         fwd_hit1,
    output logic [31:0]                  fwd_data0,
    output logic [31:0]                  fwd_data1
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          last_alu;
    logic          space;
    logic          grant_alu;
    logic          grant_mem;
    logic          push;
    logic          pop;
    logic [4:0]    push_addr;
    logic [31:0]   push_data;
    logic [PW-1:0] offset;

    // Round-robin arbiter; ready is the grant, independent of a same-cycle pop.
    always_comb begin
        space     = count < CW'(DEPTH);
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (space) begin
            if (alu_valid && mem_valid) begin
                grant_alu = !last_alu;
                grant_mem = last_alu;
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
        push_addr = grant_mem ? mem_addr : alu_addr;
        push_data = grant_mem ? mem_data : alu_data;
        // x0 requests complete the handshake but never occupy a slot
        push      = (grant_alu || grant_mem) && (push_addr != 5'd0);
        pop       = count != '0;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign busy      = (count != '0) || wr_ena;

    // Pointers, occupancy, arbitration history and the write channel register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wr_ena   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            last_alu <= 1'b0;
        end else begin
            wr_ena <= pop;
            if (pop) begin
                wr_addr <= fifo_addr[head];
                wr_data <= fifo_data[head];
                head    <= head + PW'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (grant_alu) begin
                last_alu <= 1'b1;
            end else if (grant_mem) begin
                last_alu <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_addr[tail] <= push_addr;
            fifo_data[tail] <= push_data;
        end
    end

    // Pending mask: every occupied slot plus the write currently on the channel.
    always_comb begin
        pending = '0;
        offset  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if (CW'(offset) < count) begin
                pending[fifo_addr[i]] = 1'b1;
            end
        end
        if (wr_ena) begin
            pending[wr_addr] = 1'b1;
        end
        pending[0] = 1'b0;
    end

`ifdef REGFILE_WB_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest (write channel) to youngest (tail side); later matches override.
    always_comb begin
        fwd_hit0  = 1'b0;
        fwd_hit1  = 1'b0;
        fwd_data0 = '0;
        fwd_data1 = '0;
        fwd_idx   = '0;
        if (wr_ena && wr_addr == fwd_addr0) begin
            fwd_hit0  = 1'b1;
            fwd_data0 = wr_data;
        end
        if (wr_ena && wr_addr == fwd_addr1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = wr_data;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (fifo_addr[fwd_idx] == fwd_addr0) begin
                    fwd_hit0  = 1'b1;
                    fwd_data0 = fifo_data[fwd_idx];
                end
                if (fifo_addr[fwd_idx] == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = fifo_data[fwd_idx];
                end
            end
        end
        if (fwd_addr0 == 5'd0) begin
            fwd_hit0  = 1'b0;
            fwd_data0 = '0;
        end
        if (fwd_addr1 == 5'd0) begin
            fwd_hit1  = 1'b0;
            fwd_data1 = '0;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_regfile_writeback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [4:0]    alu_addr, mem_addr;
    logic [31:0]   alu_data, mem_data;
    logic          wr_ena;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   pending;
    logic [CW-1:0] count;
    logic          busy;
`ifdef REGFILE_WB_FORWARD_EN
    logic [4:0]    fwd_addr0, fwd_addr1;
    logic          fwd_hit0, fwd_hit1;
    logic [31:0]   fwd_data0, fwd_data1;
`endif

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pending), .count(count), .busy(busy)
`ifdef REGFILE_WB_FORWARD_EN
        , .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
        .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
`endif
    );

    // Reference model: queue of outstanding writes plus the write channel.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_last_alu;
    bit          m_ena;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          checks = 0;
    int          errors = 0;

    function automatic void exp_grant(output bit ga, output bit gm);
        ga = 1'b0;
        gm = 1'b0;
        if (mq.size() >= int'(DEPTH)) return;
        if (alu_valid && mem_valid) begin
            if (m_last_alu) gm = 1'b1;
            else            ga = 1'b1;
        end else begin
            ga = alu_valid;
            gm = mem_valid;
        end
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m_ena) p[m_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic void exp_fwd(input logic [4:0] a, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a == 5'd0) return;
        if (m_ena && m_addr == a) begin hit = 1'b1; d = m_data; end
        foreach (mq[i]) if (mq[i].a == a) begin hit = 1'b1; d = mq[i].d; end
    endfunction

    // Advance one clock edge, updating the model with what the edge does.
    task automatic tick();
        bit   ga, gm;
        ent_t e;
        exp_grant(ga, gm);
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_ena = 1'b0; m_addr = '0; m_data = '0; m_last_alu = 1'b0;
        end else begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_ena = 1'b1; m_addr = e.a; m_data = e.d;
            end else begin
                m_ena = 1'b0;
            end
            if (ga) begin
                m_last_alu = 1'b1;
                if (alu_addr != 5'd0) mq.push_back('{a: alu_addr, d: alu_data});
            end else if (gm) begin
                m_last_alu = 1'b0;
                if (mem_addr != 5'd0) mq.push_back('{a: mem_addr, d: mem_data});
            end
        end
        #1;
    endtask

    task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count !== '0)     begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (wr_ena !== 1'b0)  begin errors++; $display("FAIL reset_wr_ena got %0b exp 0", wr_ena); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== '0)   begin errors++; $display("FAIL reset_wr_data got %0h exp 0", wr_data); end
        checks++; if (pending !== '0)   begin errors++; $display("FAIL reset_pending got %0h exp 0", pending); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0)
            begin errors++; $display("FAIL reset_idle_ready got %0b%0b exp 00", alu_ready, mem_ready); end
    endtask

    task automatic test_single_write();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %0b exp 1", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL single_mem_ready got %0b exp 0", mem_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (pending !== 32'h20) begin errors++; $display("FAIL single_pending1 got %0h exp 20", pending); end
        checks++; if (wr_ena !== 1'b0)    begin errors++; $display("FAIL single_early_wr got %0b exp 0", wr_ena); end
        checks++; if (count !== CW'(1))   begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        tick();
        checks++; if (wr_ena !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_write got %0b/%0d/%0h exp 1/5/deadbeef", wr_ena, wr_addr, wr_data); end
        checks++; if (pending !== 32'h20) begin errors++; $display("FAIL single_pending2 got %0h exp 20", pending); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
        tick();
        checks++; if (wr_ena !== 1'b0)    begin errors++; $display("FAIL single_wr_clear got %0b exp 0", wr_ena); end
        checks++; if (pending !== '0)     begin errors++; $display("FAIL single_pending_clear got %0h exp 0", pending); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL single_idle_busy got %0b exp 0", busy); end
    endtask

    task automatic test_x0_discard();
        drive(0, 0, 0, 1, 5'd0, 32'h1234);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL x0_mem_ready got %0b exp 1", mem_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            checks++; if (count !== '0 || wr_ena !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL x0_absorbed got cnt=%0d ena=%0b busy=%0b exp 0/0/0", count, wr_ena, busy); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int         ai = 0;
        int         mi = 0;
        int         cyc = 0;
        bit         ar, mr;
        logic [4:0] got[$];
        logic [4:0] expw;
        do_reset();
        while ((ai < 4 || mi < 4 || busy) && cyc < 40) begin
            drive(ai < 4, 5'(1 + ai), 32'(100 + ai), mi < 4, 5'(17 + mi), 32'(200 + mi));
            ar = alu_ready;
            mr = mem_ready;
            if (ai < 4 && mi < 4) begin
                checks++; if (ar !== (ai == mi) || mr !== (ai != mi))
                    begin errors++; $display("FAIL rr_grant cyc %0d got %0b%0b exp %0b%0b", cyc, ar, mr, ai == mi, ai != mi); end
            end
            checks++; if (count > CW'(DEPTH)) begin errors++; $display("FAIL rr_count got %0d exp <=%0d", count, DEPTH); end
            if (wr_ena) got.push_back(wr_addr);
            if (ar && alu_valid) ai++;
            if (mr && mem_valid) mi++;
            tick();
            cyc++;
        end
        checks++; if (cyc >= 40) begin errors++; $display("FAIL rr_timeout got ai=%0d mi=%0d exp 4/4 within 40 cycles", ai, mi); end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL rr_write_count got %0d exp 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            expw = (i % 2 == 0) ? 5'(1 + i / 2) : 5'(17 + i / 2);
            checks++; if (got[i] !== expw) begin errors++; $display("FAIL rr_order idx %0d got %0d exp %0d", i, got[i], expw); end
        end
    endtask

    task automatic test_random();
        bit ga, gm;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
            exp_grant(ga, gm);
            checks++; if (alu_ready !== ga || mem_ready !== gm)
                begin errors++; $display("FAIL rand_ready cyc %0d got %0b%0b exp %0b%0b", c, alu_ready, mem_ready, ga, gm); end
            checks++; if (wr_ena !== m_ena) begin errors++; $display("FAIL rand_wr_ena cyc %0d got %0b exp %0b", c, wr_ena, m_ena); end
            if (m_ena) begin
                checks++; if (wr_addr !== m_addr || wr_data !== m_data)
                    begin errors++; $display("FAIL rand_write cyc %0d got %0d/%0h exp %0d/%0h", c, wr_addr, wr_data, m_addr, m_data); end
            end
            checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, count, mq.size()); end
            checks++; if (pending !== exp_pending()) begin errors++; $display("FAIL rand_pending cyc %0d got %0h exp %0h", c, pending, exp_pending()); end
            checks++; if (busy !== (mq.size() != 0 || m_ena)) begin errors++; $display("FAIL rand_busy cyc %0d got %0b", c, busy); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(9 + i), 32'(32'hA0 + i), 1, 5'(12 + i), 32'(32'hB0 + i));
            tick();
        end
        rst = 1'b0;
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count !== '0 || wr_ena !== 1'b0 || pending !== '0 || busy !== 1'b0)
            begin errors++; $display("FAIL midrst_state got cnt=%0d ena=%0b pend=%0h busy=%0b exp 0", count, wr_ena, pending, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wr_ena !== 1'b0) begin errors++; $display("FAIL midrst_stale_write got addr %0d exp no write", wr_addr); end
        end
        drive(1, 5'd6, 32'h66, 1, 5'd8, 32'h88);
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0)
            begin errors++; $display("FAIL midrst_favour_alu got %0b%0b exp 10", alu_ready, mem_ready); end
        tick();
    endtask

`ifdef REGFILE_WB_FORWARD_EN
    task automatic test_forward();
        bit          eh;
        logic [31:0] ed;
        do_reset();
        fwd_addr0 = 5'd7;
        fwd_addr1 = 5'd0;
        drive(1, 5'd7, 32'h11, 0, 0, 0);
        tick();
        drive(1, 5'd7, 32'h22, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'h22)
            begin errors++; $display("FAIL fwd_youngest got %0b/%0h exp 1/22", fwd_hit0, fwd_data0); end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== '0)
            begin errors++; $display("FAIL fwd_x0 got %0b/%0h exp 0/0", fwd_hit1, fwd_data1); end
        for (int c = 0; c < 150; c++) begin
            fwd_addr0 = 5'($urandom_range(0, 7));
            fwd_addr1 = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            exp_fwd(fwd_addr0, eh, ed);
            checks++; if (fwd_hit0 !== eh || fwd_data0 !== ed)
                begin errors++; $display("FAIL fwd0 cyc %0d got %0b/%0h exp %0b/%0h", c, fwd_hit0, fwd_data0, eh, ed); end
            exp_fwd(fwd_addr1, eh, ed);
            checks++; if (fwd_hit1 !== eh || fwd_data1 !== ed)
                begin errors++; $display("FAIL fwd1 cyc %0d got %0b/%0h exp %0b/%0h", c, fwd_hit1, fwd_data1, eh, ed); end
            tick();
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        m_last_alu = 1'b0; m_ena = 1'b0; m_addr = '0; m_data = '0;
`ifdef REGFILE_WB_FORWARD_EN
        fwd_addr0 = '0; fwd_addr1 = '0;
`endif
        test_reset();
        test_single_write();
        test_x0_discard();
        test_round_robin();
        test_random();
        test_reset_midstream();
`ifdef REGFILE_WB_FORWARD_EN
        test_forward();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback sequencer on the write side of the 32×32 RISC-V register file. Accepts write requests from two producers (ALU and load unit) over valid/ready, arbitrates round-robin, buffers them in a small FIFO and drives the register file write channel with at most one write per cycle. Writes to x0 are absorbed and discarded. A per-register pending mask is exported for the hazard logic.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- alu_valid  input  1  ALU request valid
- alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
- alu_addr  input  5  ALU destination register
- alu_data  input  32  ALU result
- mem_valid  input  1  load request valid
- mem_ready  output  1  load request accepted this cycle when high with mem_valid
- mem_addr  input  5  load destination register
- mem_data  input  32  load data
- wr_ena  output  1  register file write enable
- wr_addr  output  5  register file write address
- wr_data  output  32  register file write data
- pending  output  32  bit i high while a write to xi is queued or on the write channel
- count  output  $clog2(DEPTH+1)  FIFO occupancy
- busy  output  1  count != 0 or wr_ena

## Operation
- Arbiter grants at most one source per cycle; a source can be granted only when count < DEPTH.
- One source valid: that source granted. Both valid: grant the source not granted last; a last_grant flag updates only on a grant; reset value favours ALU.
- Ungranted source sees ready low. Ready is combinational from valid, count and last_grant; it does not depend on a pop in the same cycle.
- Granted request with addr 0: ready high, nothing enqueued, last_grant still updates.
- Granted request with addr ≠ 0: {addr, data} written at the tail.
- Output stage: each edge, if count ≠ 0, pop the head into wr_addr/wr_data and set wr_ena=1; otherwise wr_ena=0 and wr_addr/wr_data hold.
- Push and pop in the same cycle are both allowed; count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count saturates by construction (no push at DEPTH, no pop at 0).
- pending is combinational: OR of decoded addresses over valid FIFO entries, plus wr_addr when wr_ena. Bit 0 is always 0.
- Order is preserved: writes reach the register file in grant order, so the last-granted write to a register wins.

## Timing
- Reset (rst low at an edge): count=0, pointers=0, wr_ena=0, wr_addr=0, wr_data=0, last_grant favours ALU, pending=0, busy=0. FIFO contents are don't-care. Reset mid-operation drops all queued writes; no write is issued in the cycle after reset.
- Latency: request accepted at edge N → wr_ena high during cycle N+1 → register file captures at edge N+2.
- Throughput: one write per cycle sustained. The FIFO never overflows because it drains every cycle.
- Full: alu_ready=mem_ready=0 while count==DEPTH, even if a pop occurs that cycle.

## Configuration
- REGFILE_WB_FORWARD_EN defined: adds inputs fwd_addr0 and fwd_addr1 (5 bits each) and outputs fwd_hit0/1 (1 bit) and fwd_data0/1 (32 bits).
  - Combinational lookup. A hit is the youngest matching entry among the FIFO entries and the output stage (FIFO tail side is youngest).
  - fwd_addr 0 never hits. On a miss, fwd_data is 0.
- Not defined: these ports are absent, with no other behaviour change.

## Test plan
- Single write: alu_valid with addr 5, data 0xDEADBEEF for one cycle → alu_ready=1; pending[5]=1 from the next cycle; wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF one cycle later; pending[5] clears after that cycle.
- x0 discard: mem_valid with addr 0, data 0x1234 → mem_ready=1; count stays 0; wr_ena never asserts; busy stays 0.
- Round-robin: both valid every cycle, ALU addr 1..4 and mem addr 17..20 → grants alternate ALU, mem, ALU, … starting with ALU after reset; wr_addr sequence is 1, 17, 2, 18, ….
- Full backpressure with DEPTH=4: fill the FIFO by holding rst low then releasing with requests pre-queued via a forced stall model, or by checking count never exceeds 4 under both sources continuously valid → ready low whenever count==4; no write lost or duplicated (scoreboard compare).
- Reset mid-stream: 3 entries queued, rst low for one edge → count=0, wr_ena=0, pending=0 next cycle; queued data is never written.
- REGFILE_WB_FORWARD_EN: queue writes to x7 of 0x11 then 0x22, fwd_addr0=7 → fwd_hit0=1, fwd_data0=0x22. With fwd_addr1=0 → fwd_hit1=0.
